// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared state encoding, default sizes and width helper for seq_detect_param
package seq_detect_pkg;

    localparam int DEF_SYM_W   = 2;
    localparam int DEF_SEQ_LEN = 4;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    // Bits needed to hold values 0..value-1; never less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_hist_shift.sv
// rtl/seq_hist_shift.sv - SEQ_LEN x SYM_W symbol history with shift-enable and flush
module seq_hist_shift
    import seq_detect_pkg::*;
#(
    parameter int SYM_W   = DEF_SYM_W,
    parameter int SEQ_LEN = DEF_SEQ_LEN
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_shift,
    input  logic                     i_flush,
    input  logic [SYM_W-1:0]         i_symbol,
    output logic [SEQ_LEN*SYM_W-1:0] o_next
);

    localparam int HW = SEQ_LEN * SYM_W;

    logic [HW-1:0] hist_q;
    logic [HW-1:0] hist_next;

    // Newest symbol enters the top slot; slot 0 holds the oldest.
    generate
        if (SEQ_LEN == 1) begin : g_single
            assign hist_next = i_symbol;
        end else begin : g_multi
            assign hist_next = {i_symbol, hist_q[HW-1:SYM_W]};
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_q <= '0;
        end else if (i_flush) begin
            hist_q <= '0;
        end else if (i_shift) begin
            hist_q <= hist_next;
        end
    end

    assign o_next = hist_next;

    // The oldest slot is shifted out before it is ever compared again.
    wire unused_oldest = ^hist_q[SYM_W-1:0];

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised symbol-sequence detector; SEQ_DETECT_TIMEOUT_EN adds idle flush
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int SYM_W   = DEF_SYM_W,
    parameter int SEQ_LEN = DEF_SEQ_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_load,
    input  logic [SEQ_LEN*SYM_W-1:0] i_pattern,
    input  logic                     i_overlap,
    input  logic                     i_valid,
    input  logic [SYM_W-1:0]         i_symbol,
    output logic                     o_match,
    output logic [CNT_W-1:0]         o_match_cnt,
    output logic                     o_armed
);

    localparam int                FILL_W    = clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);

    state_t                   state_q, state_d;
    logic [FILL_W-1:0]        fill_q, fill_d, fill_inc;
    logic [SEQ_LEN*SYM_W-1:0] pattern_q;
    logic [SEQ_LEN*SYM_W-1:0] hist_next;
    logic [CNT_W-1:0]         cnt_q;
    logic                     match_q;
    logic                     shift;
    logic                     flush;
    logic                     timeout;
    logic                     hit;

    // A load cycle discards any symbol presented alongside it.
    assign shift = i_valid && !i_load;
    assign flush = i_load || timeout;

`ifdef SEQ_DETECT_TIMEOUT_EN
    localparam int              IDLE_W    = clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_q;

    assign timeout = !i_valid && !i_load && (idle_q == IDLE_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_q <= '0;
        end else if (i_valid || i_load || timeout) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    wire unused_timeout = (TIMEOUT > 0);
`endif

    seq_hist_shift #(
        .SYM_W   (SYM_W),
        .SEQ_LEN (SEQ_LEN)
    ) u_hist (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_shift  (shift),
        .i_flush  (flush),
        .i_symbol (i_symbol),
        .o_next   (hist_next)
    );

    always_comb begin
        fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
        hit      = shift && (hist_next == pattern_q) && (fill_inc == FILL_FULL);
        state_d  = state_q;
        fill_d   = fill_q;
        if (flush) begin
            state_d = S_FILL;
            fill_d  = '0;
        end else if (shift) begin
            if (hit && !i_overlap) begin
                state_d = S_FILL;
                fill_d  = '0;
            end else begin
                fill_d = fill_inc;
                if (fill_inc == FILL_FULL) begin
                    state_d = S_ARMED;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_FILL;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pattern_q <= '0;
        end else if (i_load) begin
            pattern_q <= i_pattern;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            match_q <= hit;
            if (hit && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_match     = match_q;
    assign o_match_cnt = cnt_q;
    assign o_armed     = (state_q == S_ARMED);

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed self-checking bench for seq_detect_param
module tb_seq_detect_param;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [7:0] pattern;
    logic       overlap;
    logic       valid;
    logic [1:0] symbol;

    logic       match;
    logic [7:0] cnt;
    logic       armed;
    logic       sat_match;
    logic [1:0] sat_cnt;
    logic       sat_armed;
    logic       one_match;
    logic [7:0] one_cnt;
    logic       one_armed;

    int n_checks;
    int n_fail;

    seq_detect_param #(.SYM_W(2), .SEQ_LEN(4), .CNT_W(8), .TIMEOUT(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_pattern(pattern),
        .i_overlap(overlap), .i_valid(valid), .i_symbol(symbol),
        .o_match(match), .o_match_cnt(cnt), .o_armed(armed)
    );

    seq_detect_param #(.SYM_W(2), .SEQ_LEN(4), .CNT_W(2), .TIMEOUT(16)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_pattern(pattern),
        .i_overlap(overlap), .i_valid(valid), .i_symbol(symbol),
        .o_match(sat_match), .o_match_cnt(sat_cnt), .o_armed(sat_armed)
    );

    seq_detect_param #(.SYM_W(2), .SEQ_LEN(1), .CNT_W(8), .TIMEOUT(16)) u_one (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_pattern(pattern[1:0]),
        .i_overlap(overlap), .i_valid(valid), .i_symbol(symbol),
        .o_match(one_match), .o_match_cnt(one_cnt), .o_armed(one_armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        load  = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_pat(input logic [7:0] p);
        @(negedge clk);
        load    = 1'b1;
        pattern = p;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic send(input logic [1:0] s);
        @(negedge clk);
        valid  = 1'b1;
        symbol = s;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; pattern = '0; overlap = 1'b1; valid = 1'b0; symbol = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({match, cnt, armed, one_armed} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=0", {match, cnt, armed, one_armed});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_overlap();
        load_pat(8'h55);
        overlap = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            send(2'b01);
            n_checks++;
            if (match !== (i >= 4)) begin
                n_fail++;
                $display("FAIL ovl_match sym=%0d got=%b exp=%b", i, match, (i >= 4));
            end
        end
        n_checks++;
        if (cnt !== 8'd3 || armed !== 1'b1) begin
            n_fail++;
            $display("FAIL ovl_cnt_armed got=%0d/%b exp=3/1", cnt, armed);
        end
    endtask

    task automatic test_non_overlap();
        do_reset();
        load_pat(8'h55);
        overlap = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            send(2'b01);
            n_checks++;
            if (match !== (i == 4)) begin
                n_fail++;
                $display("FAIL novl_match sym=%0d got=%b exp=%b", i, match, (i == 4));
            end
            if (i == 4) begin
                n_checks++;
                if (armed !== 1'b0) begin
                    n_fail++;
                    $display("FAIL novl_armed got=%b exp=0", armed);
                end
            end
        end
        n_checks++;
        if (cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL novl_cnt got=%0d exp=1", cnt);
        end
    endtask

    task automatic test_gapped_pattern();
        logic [1:0] seq [7];
        seq = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11};
        do_reset();
        load_pat(8'hE4);
        overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(seq[i]);
            n_checks++;
            if (match !== (i == 6)) begin
                n_fail++;
                $display("FAIL gap_match idx=%0d got=%b exp=%b", i, match, (i == 6));
            end
            if (i < 6) idle(3);
        end
        idle(1);
        n_checks++;
        if (match !== 1'b0 || cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL gap_after got=%b/%0d exp=0/1", match, cnt);
        end
    endtask

    task automatic test_saturate();
        int exp_c;
        do_reset();
        load_pat(8'h55);
        overlap = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            send(2'b01);
            exp_c = (i < 4) ? 0 : ((i - 3 > 3) ? 3 : i - 3);
            n_checks++;
            if (sat_cnt !== 2'(exp_c)) begin
                n_fail++;
                $display("FAIL sat_cnt sym=%0d got=%0d exp=%0d", i, sat_cnt, exp_c);
            end
        end
        n_checks++;
        if (cnt !== 8'd7) begin
            n_fail++;
            $display("FAIL sat_wide_cnt got=%0d exp=7", cnt);
        end
    endtask

    task automatic test_load_and_async_reset();
        do_reset();
        load_pat(8'h55);
        overlap = 1'b1;
        repeat (3) send(2'b01);
        @(negedge clk);
        load = 1'b1; valid = 1'b1; symbol = 2'b01; pattern = 8'h55;
        @(posedge clk);
        #1 load = 1'b0; valid = 1'b0;
        n_checks++;
        if (match !== 1'b0 || armed !== 1'b0) begin
            n_fail++;
            $display("FAIL load_wins got=%b/%b exp=0/0", match, armed);
        end
        for (int i = 1; i <= 4; i++) begin
            send(2'b01);
            n_checks++;
            if (match !== (i == 4)) begin
                n_fail++;
                $display("FAIL reload_match sym=%0d got=%b exp=%b", i, match, (i == 4));
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({match, cnt, armed} !== 10'd0) begin
            n_fail++;
            $display("FAIL async_reset got=%b exp=0", {match, cnt, armed});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        logic exp16;
`ifdef SEQ_DETECT_TIMEOUT_EN
        exp16 = 1'b0;
`else
        exp16 = 1'b1;
`endif
        do_reset();
        load_pat(8'h55);
        overlap = 1'b1;
        repeat (3) send(2'b01);
        idle(16);
        send(2'b01);
        n_checks++;
        if (match !== exp16) begin
            n_fail++;
            $display("FAIL idle16_match got=%b exp=%b", match, exp16);
        end
        do_reset();
        load_pat(8'h55);
        repeat (3) send(2'b01);
        idle(15);
        send(2'b01);
        n_checks++;
        if (match !== 1'b1) begin
            n_fail++;
            $display("FAIL idle15_match got=%b exp=1", match);
        end
    endtask

    task automatic test_seq_len_one();
        do_reset();
        load_pat(8'h02);
        overlap = 1'b1;
        n_checks++;
        if (one_armed !== 1'b0) begin
            n_fail++;
            $display("FAIL one_armed_init got=%b exp=0", one_armed);
        end
        send(2'b10);
        n_checks++;
        if (one_match !== 1'b1 || one_armed !== 1'b1) begin
            n_fail++;
            $display("FAIL one_first got=%b/%b exp=1/1", one_match, one_armed);
        end
        send(2'b01);
        n_checks++;
        if (one_match !== 1'b0) begin
            n_fail++;
            $display("FAIL one_miss got=%b exp=0", one_match);
        end
        send(2'b10);
        n_checks++;
        if (one_match !== 1'b1 || one_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL one_second got=%b/%0d exp=1/2", one_match, one_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gapped_pattern();
        test_saturate();
        test_load_and_async_reset();
        test_timeout();
        test_seq_len_one();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
